// File: rtl/hazard_controller.sv
// hazard_controller
//
// Hazard and sequencing controller for a 5-stage MIPS pipeline. It decodes the
// instruction sitting in ID, tracks the destination registers of the
// instructions in EX, MEM and WB with a small shadow scoreboard, and from that
// produces the stall/flush/bubble controls plus registered forwarding selects
// that line up with the instruction once it reaches EX. Two saturating
// counters record load-use stall cycles and flush events.
//
// Ports
//   clk          : core clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   IR           : instruction currently held in the IF/ID register
//   branch_taken : beq in EX resolved taken this cycle
//   pc_en        : PC write enable
//   ifid_en      : IF/ID register write enable
//   ifid_flush   : IF/ID loads a NOP at the next edge
//   idex_bubble  : ID/EX loads a bubble at the next edge
//   fwd_a/fwd_b  : operand source for the instruction in EX
//                  (0 regfile, 1 EX/MEM, 2 MEM/WB, 3 WB-hold)
//   stall_cnt    : saturating count of load-use stall cycles
//   flush_cnt    : saturating count of flush events

module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Scoreboard slots: a slot is valid only when its instruction writes a
  // nonzero register, so $0 can never become a forwarding source.
  logic       exValid_q,  memValid_q,  wbValid_q;
  logic [4:0] exDest_q,   memDest_q,   wbDest_q;
  logic       exLoad_q;

  logic [1:0]       fwdA_q, fwdB_q;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  // ID-stage decode results
  logic [5:0] opcode, funct;
  logic [4:0] idDest, srcA, srcB;
  logic       idLoad, idJump, idValid;
  logic       loadUse;
  logic [1:0] fwdA_d, fwdB_d;

  // Decode: unused sources are reported as $0, which never matches a slot.
  always_comb begin
    opcode = IR[31:26];
    funct  = IR[5:0];
    idDest = 5'd0;
    srcA   = 5'd0;
    srcB   = 5'd0;
    idLoad = 1'b0;
    idJump = 1'b0;
    case (opcode)
      6'd0: begin
        if (funct == 6'd32 || funct == 6'd34 || funct == 6'd42) begin
          idDest = IR[15:11];
          srcA   = IR[25:21];
          srcB   = IR[20:16];
        end
      end
      6'd35: begin
        idDest = IR[20:16];
        srcA   = IR[25:21];
        idLoad = 1'b1;
      end
      6'd43, 6'd4: begin
        srcA = IR[25:21];
        srcB = IR[20:16];
      end
      6'd2: idJump = 1'b1;
      default: ;
    endcase
    idValid = (idDest != 5'd0);
  end

  // Youngest producer wins: EX, then MEM, then WB (WB covers the register
  // file returning the stale value on a same-edge write).
  function automatic logic [1:0] fwdSelect(
    input logic [4:0] src,
    input logic       exV,  input logic [4:0] exD,
    input logic       memV, input logic [4:0] memD,
    input logic       wbV,  input logic [4:0] wbD
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (exV && exD == src)        sel = FWD_EX;
      else if (memV && memD == src) sel = FWD_MEM;
      else if (wbV && wbD == src)   sel = FWD_WB;
    end
    return sel;
  endfunction

  // Hazard detection and control priority: reset, taken branch, load-use,
  // jump, normal flow.
  always_comb begin
    loadUse = exValid_q && exLoad_q &&
              ((srcA != 5'd0 && srcA == exDest_q) ||
               (srcB != 5'd0 && srcB == exDest_q));
    fwdA_d = fwdSelect(srcA, exValid_q, exDest_q, memValid_q, memDest_q,
                       wbValid_q, wbDest_q);
    fwdB_d = fwdSelect(srcB, exValid_q, exDest_q, memValid_q, memDest_q,
                       wbValid_q, wbDest_q);

    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (loadUse) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (idJump) begin
      ifid_flush  = 1'b1;
    end
  end

  // Scoreboard shift, registered forwarding selects and saturating counters.
  // The stall count ignores load-use when a taken branch squashes ID anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q  <= 1'b0;
      exDest_q   <= 5'd0;
      exLoad_q   <= 1'b0;
      memValid_q <= 1'b0;
      memDest_q  <= 5'd0;
      wbValid_q  <= 1'b0;
      wbDest_q   <= 5'd0;
      fwdA_q     <= FWD_RF;
      fwdB_q     <= FWD_RF;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      wbValid_q  <= memValid_q;
      wbDest_q   <= memDest_q;
      memValid_q <= exValid_q;
      memDest_q  <= exDest_q;
      if (idex_bubble) begin
        exValid_q <= 1'b0;
        exDest_q  <= 5'd0;
        exLoad_q  <= 1'b0;
        fwdA_q    <= FWD_RF;
        fwdB_q    <= FWD_RF;
      end else begin
        exValid_q <= idValid;
        exDest_q  <= idDest;
        exLoad_q  <= idLoad;
        fwdA_q    <= fwdA_d;
        fwdB_q    <= fwdB_d;
      end
      if (loadUse && !branch_taken && stallCnt_q != '1)
        stallCnt_q <= stallCnt_q + 1'b1;
      if (ifid_flush && flushCnt_q != '1)
        flushCnt_q <= flushCnt_q + 1'b1;
    end
  end

  assign fwd_a     = fwdA_q;
  assign fwd_b     = fwdB_q;
  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//
// Directed bench for hazard_controller. Inputs change just after the falling
// edge; combinational controls are checked 1 ns later, and registered outputs
// reflect the rising edge that preceded the latest input change.

module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic [31:0] IR;
  logic        branch_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks;
  int failures;

  hazard_controller #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .IR           (IR),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] lwInstr(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd35, rs, rt, 16'd0};
  endfunction

  // Jump whose target bits alias register fields to $14, so a decoder that
  // wrongly gave j a destination would create a visible forward.
  function automatic logic [31:0] jInstr();
    return {6'd2, 5'd14, 5'd14, 5'd14, 11'd0};
  endfunction

  localparam logic [31:0] NOP = 32'd0;

  // Wait for the falling edge, drive the inputs, then let comb logic settle.
  task automatic applyStimulus(input logic [31:0] ir, input logic br, input logic r);
    @(negedge clk);
    IR           = ir;
    branch_taken = br;
    rst          = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic pc, input logic en,
                           input logic fl, input logic bub);
    checkOutput({tag, ".pc_en"},       {31'd0, pc_en},       {31'd0, pc});
    checkOutput({tag, ".ifid_en"},     {31'd0, ifid_en},     {31'd0, en});
    checkOutput({tag, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, fl});
    checkOutput({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, bub});
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    IR           = NOP;
    branch_taken = 1'b0;

    // Reset: forced controls, cleared registered state
    applyStimulus(NOP, 1'b0, 1'b1);
    checkCtrl("rst_ctrl", 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(NOP, 1'b0, 1'b1);
    checkOutput("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    checkOutput("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    // Back-to-back: add $3,$1,$2 ; sub $4,$3,$1
    applyStimulus(rType(5'd1, 5'd2, 5'd3, 6'd32), 1'b0, 1'b0);
    checkCtrl("b2b_add", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(rType(5'd3, 5'd1, 5'd4, 6'd34), 1'b0, 1'b0);
    checkCtrl("b2b_sub", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_add_fwd_a", {30'd0, fwd_a}, 32'd0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("b2b_sub_fwd_a", {30'd0, fwd_a}, 32'd1);
    checkOutput("b2b_sub_fwd_b", {30'd0, fwd_b}, 32'd0);

    // Load-use: lw $5,0($1) ; add $6,$5,$5
    applyStimulus(lwInstr(5'd1, 5'd5), 1'b0, 1'b0);
    checkCtrl("lu_lw", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(rType(5'd5, 5'd5, 5'd6, 6'd32), 1'b0, 1'b0);
    checkCtrl("lu_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(rType(5'd5, 5'd5, 5'd6, 6'd32), 1'b0, 1'b0);
    checkCtrl("lu_resume", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_bubble_fwd_a", {30'd0, fwd_a}, 32'd0);
    checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
    checkOutput("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
    checkOutput("lu_stall_cnt_hold", {16'd0, stall_cnt}, 32'd1);

    // Distance 3: add $7,$1,$2 ; nop ; nop ; sub $8,$7,$0
    applyStimulus(rType(5'd1, 5'd2, 5'd7, 6'd32), 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    applyStimulus(rType(5'd7, 5'd0, 5'd8, 6'd34), 1'b0, 1'b0);
    checkCtrl("d3_sub", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("d3_fwd_a", {30'd0, fwd_a}, 32'd3);
    checkOutput("d3_fwd_b", {30'd0, fwd_b}, 32'd0);
    checkOutput("d3_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    // Writes to $0 never forward: add $0,$1,$2 ; slt $9,$0,$0
    applyStimulus(rType(5'd1, 5'd2, 5'd0, 6'd32), 1'b0, 1'b0);
    applyStimulus(rType(5'd0, 5'd0, 5'd9, 6'd42), 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("zero_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Branch taken during a load-use: lw $11 ; add $12,$11,$1 with branch
    applyStimulus(lwInstr(5'd1, 5'd11), 1'b0, 1'b0);
    applyStimulus(rType(5'd11, 5'd1, 5'd12, 6'd32), 1'b1, 1'b0);
    checkCtrl("br_ctrl", 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("br_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    checkOutput("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    checkOutput("br_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Jump: one IF/ID flush, no bubble, no destination
    applyStimulus(jInstr(), 1'b0, 1'b0);
    checkCtrl("j_ctrl", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(rType(5'd14, 5'd14, 5'd15, 6'd32), 1'b0, 1'b0);
    checkCtrl("j_after", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("j_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("j_nodest_fwd_a", {30'd0, fwd_a}, 32'd0);
    checkOutput("j_nodest_fwd_b", {30'd0, fwd_b}, 32'd0);

    // Jump and taken branch together count as one flush
    applyStimulus(jInstr(), 1'b1, 1'b0);
    checkCtrl("jbr_ctrl", 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("jbr_flush_cnt", {16'd0, flush_cnt}, 32'd3);

    // Saturate flush_cnt with a long run of jumps
    for (int i = 0; i < 65540; i++) applyStimulus(jInstr(), 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("sat_flush_cnt", {16'd0, flush_cnt}, 32'h0000_FFFF);
    applyStimulus(jInstr(), 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("sat_flush_hold", {16'd0, flush_cnt}, 32'h0000_FFFF);

    // Reset during a load-use stall: lw $16 ; add $17,$16,$0
    applyStimulus(lwInstr(5'd1, 5'd16), 1'b0, 1'b0);
    applyStimulus(rType(5'd16, 5'd0, 5'd17, 6'd32), 1'b0, 1'b0);
    checkCtrl("mid_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(rType(5'd16, 5'd0, 5'd17, 6'd32), 1'b0, 1'b1);
    checkCtrl("mid_rst_ctrl", 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_pre_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    applyStimulus(rType(5'd16, 5'd0, 5'd17, 6'd32), 1'b0, 1'b0);
    checkOutput("mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    checkOutput("mid_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    checkCtrl("mid_release", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(NOP, 1'b0, 1'b0);
    checkOutput("mid_release_fwd_a", {30'd0, fwd_a}, 32'd0);
    checkOutput("mid_release_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It watches the instruction in ID and the taken-branch result from EX, and keeps a shadow scoreboard of destination registers for the instructions in EX, MEM and WB. From that it drives PC/IF-ID enables, flushes and ID/EX bubbles, and registered operand-forwarding selects aligned with the EX stage. It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the performance counters
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- IR  in  32  instruction currently in ID (IF/ID register)
- branch_taken  in  1  beq in EX resolved taken this cycle
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID loads a NOP at next edge
- idex_bubble  out  1  ID/EX loads a bubble (RD=0, no side effects) at next edge
- fwd_a  out  2  registered operand-A source for the instruction now in EX: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 WB-hold (value written back the previous cycle)
- fwd_b  out  2  same encoding, operand B
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles
- flush_cnt  out  CNT_W  saturating count of flush events

## Operation
- Decode of IR (opcode IR[31:26], funct IR[5:0]):
  - R-type (op 0, funct 32/34/42): dest IR[15:11]; srcs rs=IR[25:21], rt=IR[20:16]
  - lw (35): dest rt; src rs; is_load=1
  - sw (43), beq (4): no dest; srcs rs, rt
  - j (2): no dest, no srcs; is_jump=1
  - anything else, including unlisted R-type funct: NOP, no dest, no srcs
  - dest 0 counts as no dest; src 0 never matches.
- Scoreboard slots EX, MEM, WB each hold {valid, dest[4:0], is_load}. Every edge: WB<=MEM, MEM<=EX, EX<=decode(IR), or empty if idex_bubble.
- Load-use: EX slot is_load and its dest equals an ID src -> load_use=1.
- Control priority, evaluated combinationally each cycle:
  - branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1; load_use is ignored.
  - else load_use: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - else is_jump: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=0.
  - else: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Forwarding is computed in ID per src and registered at the edge into fwd_a/fwd_b. The youngest producer wins:
  - match EX slot -> 1
  - else match MEM slot -> 2
  - else match WB slot -> 3 (the register file returns the stale value on a same-edge write)
  - else 0
  - The EX-slot match is never a load, because load_use stalls first.
  - When idex_bubble=1, fwd_a/fwd_b load 0.
- Counters:
  - stall_cnt +1 per cycle where load_use=1 and branch_taken=0.
  - flush_cnt +1 per cycle where ifid_flush=1; a simultaneous jump and branch counts once.
  - Both saturate at all-ones.

## Timing
- While rst=1 and at the edge where it is sampled:
  - scoreboard slots invalid; fwd_a=fwd_b=0; stall_cnt=flush_cnt=0
  - combinational outputs forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1
- Reset mid-operation discards all slots. There is no hazard carry-over after release.
- Control outputs are combinational from IR, branch_taken and the slots. There is no added latency; they act at the next edge.
- fwd_a/fwd_b have 1-cycle latency and are valid while the matching instruction is in EX.
- Load-use costs exactly 1 stall cycle:
  - The load moves to MEM and the EX slot becomes empty.
  - The next cycle the ID consumer matches MEM and gets fwd=2.
- A taken branch costs 2 bubbles (IF/ID and ID/EX). A jump costs 1 (IF/ID).
- A load-use in the same cycle as branch_taken produces no stall and no stall_cnt increment.

## Test plan
- Back-to-back dependency: add $3,$1,$2 then sub $4,$3,$1. The sub's EX cycle has fwd_a=1, fwd_b=0, and there is no stall.
- Load-use: lw $5,0($1) then add $6,$5,$5. There is exactly one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then add in EX with fwd_a=fwd_b=2; stall_cnt=1.
- Distance-3 dependency: add $7,..., two NOPs, then sub $8,$7,$0. EX has fwd_a=3. With $0 as the source, fwd_b=0, and writes to $0 never forward.
- Branch vs stall: branch_taken=1 in the same cycle as a load-use in ID. ifid_flush=1, idex_bubble=1, pc_en=1, stall_cnt unchanged, flush_cnt +1.
- Jump: j in ID. ifid_flush=1 for one cycle, idex_bubble=0, then the jump enters EX with no dest. Drive flush_cnt to all-ones and confirm it holds there.
- Reset mid-stream: assert rst during a load-use stall. The next cycle shows fwd=0, counters=0 and the forced reset outputs. After release, a previously pending dependency produces no stall.
